// File: rtl/icache_pkg.sv
// Shared definitions for the direct-mapped instruction cache: FSM states,
// default geometry and the address field extraction helper.
package icache_pkg;

  localparam int DEF_INDEX_WIDTH  = 3;
  localparam int DEF_OFFSET_WIDTH = 2;

  typedef enum logic {
    S_IDLE = 1'b0,
    S_FILL = 1'b1
  } state_t;

  // Returns addr[lsb +: width], zero-extended to a full word.
  function automatic logic [31:0] addr_field(input logic [31:0] addr,
                                             input int          lsb,
                                             input int          width);
    logic [31:0] mask;
    mask = (width >= 32) ? '1 : ((32'd1 << width) - 32'd1);
    return (addr >> lsb) & mask;
  endfunction

endpackage

// File: rtl/icache_ctrl.sv
// Miss handling for icache_dm: fill FSM, sequential word requests to memory
// and saturating hit/miss statistics.
module icache_ctrl
  import icache_pkg::*;
#(
  parameter int INDEX_WIDTH  = DEF_INDEX_WIDTH,
  parameter int OFFSET_WIDTH = DEF_OFFSET_WIDTH,
  parameter int TAG_WIDTH    = 32 - INDEX_WIDTH - OFFSET_WIDTH
) (
  input  logic                    clk,
  input  logic                    rst,
  input  logic                    cpu_ren,
  input  logic                    hit,
  input  logic [TAG_WIDTH-1:0]    req_tag,
  input  logic [INDEX_WIDTH-1:0]  req_index,
  input  logic                    mem_ack,
  output logic                    fill_start,
  output logic                    fill_we,
  output logic                    fill_last,
  output logic [TAG_WIDTH-1:0]    fill_tag,
  output logic [INDEX_WIDTH-1:0]  fill_index,
  output logic [OFFSET_WIDTH-1:0] fill_cnt,
  output logic [31:0]             mem_addr,
  output logic                    mem_ren,
  output logic [31:0]             hit_cnt,
  output logic [31:0]             miss_cnt
);

  state_t state_q, state_d;
  logic   is_last;

  assign is_last = (fill_cnt == '1);

  always_comb begin
    state_d    = state_q;
    fill_start = 1'b0;
    fill_we    = 1'b0;
    fill_last  = 1'b0;
    mem_ren    = 1'b0;
    mem_addr   = '0;
    unique case (state_q)
      S_IDLE: begin
        if (cpu_ren && !hit) begin
          fill_start = 1'b1;
          state_d    = S_FILL;
        end
      end
      S_FILL: begin
        mem_addr  = {fill_tag, fill_index, fill_cnt};
        // Held high between words so memory restarts at once; dropped with the final ack.
        mem_ren   = !(mem_ack && is_last);
        fill_we   = mem_ack;
        fill_last = mem_ack && is_last;
        if (fill_last) state_d = S_IDLE;
      end
      default: state_d = S_IDLE;
    endcase
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      state_q  <= S_IDLE;
      fill_cnt <= '0;
    end else begin
      state_q <= state_d;
      if (fill_start)   fill_cnt <= '0;
      else if (fill_we) fill_cnt <= fill_cnt + 1'b1;
    end
  end

  // The line being filled is latched so the CPU may move on mid-fill.
  always_ff @(posedge clk) begin
    if (fill_start) begin
      fill_tag   <= req_tag;
      fill_index <= req_index;
    end
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      hit_cnt  <= '0;
      miss_cnt <= '0;
    end else begin
      if (cpu_ren && hit && (hit_cnt != '1))   hit_cnt  <= hit_cnt + 32'd1;
      if (fill_start && (miss_cnt != '1))      miss_cnt <= miss_cnt + 32'd1;
    end
  end

endmodule

// File: rtl/icache_dm.sv
// Direct-mapped read-only instruction cache: line storage and the zero-latency
// hit path; miss handling lives in icache_ctrl.
module icache_dm
  import icache_pkg::*;
#(
  parameter int INDEX_WIDTH  = DEF_INDEX_WIDTH,
  parameter int OFFSET_WIDTH = DEF_OFFSET_WIDTH,
  parameter int TAG_WIDTH    = 32 - INDEX_WIDTH - OFFSET_WIDTH
) (
  input  logic        clk,
  input  logic        rst,
  input  logic [31:0] cpu_addr,
  input  logic        cpu_ren,
  output logic [31:0] cpu_dout,
  output logic        cpu_stall,
  output logic [31:0] mem_addr,
  output logic        mem_ren,
  input  logic [31:0] mem_din,
  input  logic        mem_ack,
  output logic [31:0] hit_cnt,
  output logic [31:0] miss_cnt
);

  localparam int LINES = 1 << INDEX_WIDTH;
  localparam int WORDS = 1 << OFFSET_WIDTH;

  logic [LINES-1:0]     valid_q;
  logic [TAG_WIDTH-1:0] tag_q  [LINES];
  logic [31:0]          data_q [LINES][WORDS];

  logic [TAG_WIDTH-1:0]    req_tag;
  logic [INDEX_WIDTH-1:0]  req_index;
  logic [OFFSET_WIDTH-1:0] req_offset;
  logic [31:0]             req_tag_ext;
  logic [31:0]             line_tag_ext;
  logic                    hit;

  logic                    fill_start;
  logic                    fill_we;
  logic                    fill_last;
  logic [TAG_WIDTH-1:0]    fill_tag;
  logic [INDEX_WIDTH-1:0]  fill_index;
  logic [OFFSET_WIDTH-1:0] fill_cnt;

  assign req_tag      = cpu_addr[31 -: TAG_WIDTH];
  assign req_index    = cpu_addr[OFFSET_WIDTH +: INDEX_WIDTH];
  assign req_offset   = cpu_addr[OFFSET_WIDTH-1:0];
  assign req_tag_ext  = addr_field(cpu_addr, INDEX_WIDTH + OFFSET_WIDTH, TAG_WIDTH);
  assign line_tag_ext = 32'(tag_q[req_index]);

  // Evaluated on the arrays before any write this cycle, so a completing fill
  // is only visible from the following cycle.
  assign hit       = valid_q[req_index] && (line_tag_ext == req_tag_ext);
  assign cpu_stall = cpu_ren && !hit;
  assign cpu_dout  = (cpu_ren && hit) ? data_q[req_index][req_offset] : '0;

  always_ff @(posedge clk) begin
    if (rst) begin
      valid_q <= '0;
    end else begin
      if (fill_start) valid_q[req_index]  <= 1'b0;
      if (fill_last)  valid_q[fill_index] <= 1'b1;
    end
  end

  always_ff @(posedge clk) begin
    if (fill_we)   data_q[fill_index][fill_cnt] <= mem_din;
    if (fill_last) tag_q[fill_index]            <= fill_tag;
  end

  icache_ctrl #(
    .INDEX_WIDTH (INDEX_WIDTH),
    .OFFSET_WIDTH(OFFSET_WIDTH),
    .TAG_WIDTH   (TAG_WIDTH)
  ) u_ctrl (
    .clk       (clk),
    .rst       (rst),
    .cpu_ren   (cpu_ren),
    .hit       (hit),
    .req_tag   (req_tag),
    .req_index (req_index),
    .mem_ack   (mem_ack),
    .fill_start(fill_start),
    .fill_we   (fill_we),
    .fill_last (fill_last),
    .fill_tag  (fill_tag),
    .fill_index(fill_index),
    .fill_cnt  (fill_cnt),
    .mem_addr  (mem_addr),
    .mem_ren   (mem_ren),
    .hit_cnt   (hit_cnt),
    .miss_cnt  (miss_cnt)
  );

endmodule

// File: tb/tb_icache_dm.sv
// Bench for icache_dm: slow memory responder, line-level reference model and
// a scoreboard fed by the fetch stimulus and drained by an output monitor.
module tb_icache_dm;

  localparam int DELAY = 3;

  logic        clk = 1'b0;
  logic        rst;
  logic [31:0] cpu_addr;
  logic        cpu_ren;
  logic [31:0] cpu_dout;
  logic        cpu_stall;
  logic [31:0] mem_addr;
  logic        mem_ren;
  logic [31:0] mem_din;
  logic        mem_ack;
  logic [31:0] hit_cnt;
  logic [31:0] miss_cnt;

  int vectors = 0;
  int errors  = 0;

  always #5 clk = ~clk;

  icache_dm dut (
    .clk      (clk),
    .rst      (rst),
    .cpu_addr (cpu_addr),
    .cpu_ren  (cpu_ren),
    .cpu_dout (cpu_dout),
    .cpu_stall(cpu_stall),
    .mem_addr (mem_addr),
    .mem_ren  (mem_ren),
    .mem_din  (mem_din),
    .mem_ack  (mem_ack),
    .hit_cnt  (hit_cnt),
    .miss_cnt (miss_cnt)
  );

  function automatic logic [31:0] memword(input logic [31:0] a);
    return 32'hA000_0000 + a;
  endfunction

  // Slow memory: accepts a request, acks DELAY edges later with one word.
  logic        mem_ack_r;
  logic [31:0] mem_din_r;
  logic        busy;
  int          dly;
  logic [31:0] lat_addr;
  logic        spur_ack;
  logic [31:0] spur_din;

  assign mem_ack = mem_ack_r | spur_ack;
  assign mem_din = spur_ack ? spur_din : mem_din_r;

  always @(posedge clk) begin
    if (rst) begin
      busy      <= 1'b0;
      mem_ack_r <= 1'b0;
      mem_din_r <= '0;
      dly       <= 0;
      lat_addr  <= '0;
    end else begin
      mem_ack_r <= 1'b0;
      if (busy) begin
        if (dly <= 1) begin
          mem_ack_r <= 1'b1;
          mem_din_r <= memword(lat_addr);
          busy      <= 1'b0;
        end else begin
          dly <= dly - 1;
        end
      end else if (mem_ren && !mem_ack_r) begin
        busy     <= 1'b1;
        dly      <= DELAY;
        lat_addr <= mem_addr;
      end
    end
  end

  // Reference model: which memory line each cache slot holds.
  bit          mv [8];
  logic [31:0] mt [8];
  int          exp_hits;
  int          exp_misses;
  logic [31:0] exp_q [$];

  function automatic int slot_of(input logic [31:0] a);
    return int'((a / 4) % 8);
  endfunction

  function automatic bit model_hit(input logic [31:0] a);
    return mv[slot_of(a)] && (mt[slot_of(a)] == a / 32);
  endfunction

  task automatic model_fill(input logic [31:0] a);
    mv[slot_of(a)] = 1'b1;
    mt[slot_of(a)] = a / 32;
    exp_misses++;
  endtask

  task automatic model_reset();
    for (int i = 0; i < 8; i++) mv[i] = 1'b0;
    exp_hits   = 0;
    exp_misses = 0;
    exp_q.delete();
  endtask

  task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
    vectors++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %h, expected %h (t=%0t)", nm, act, exp, $time);
    end
  endtask

  // Monitor: every delivered word is checked against the scoreboard.
  always @(negedge clk) begin
    if (rst === 1'b0) begin
      if (cpu_ren && !cpu_stall) begin
        if (exp_q.size() == 0) chk("unexpected_dout", cpu_dout, 32'hxxxx_xxxx);
        else                   chk("dout", cpu_dout, exp_q.pop_front());
      end else begin
        chk("dout_idle_zero", cpu_dout, 32'h0);
      end
    end
  end

  task automatic cnt_chk();
    chk("hit_cnt", hit_cnt, exp_hits);
    chk("miss_cnt", miss_cnt, exp_misses);
  endtask

  task automatic do_reset();
    rst = 1'b1;
    @(posedge clk); #1;
    @(posedge clk); #1;
    rst = 1'b0;
    model_reset();
  endtask

  // One fetch, held until the word is delivered; leaves cpu_ren high.
  task automatic fetch(input logic [31:0] a);
    bit h, last_ack;
    int acks, n;
    h = model_hit(a);
    exp_q.push_back(memword(a));
    cpu_addr = a;
    cpu_ren  = 1'b1;
    acks = 0; n = 0; last_ack = 1'b0;
    forever begin
      @(negedge clk);
      if (!cpu_stall) break;
      if (mem_ack) begin
        chk("fill_addr", mem_addr, {a[31:2], 2'(acks)});
        chk("mem_ren_at_ack", 32'(mem_ren), (acks == 3) ? 32'd0 : 32'd1);
        acks++;
        last_ack = 1'b1;
      end else begin
        chk("mem_ren_stall", 32'(mem_ren), (n > 0) ? 32'd1 : 32'd0);
        last_ack = 1'b0;
      end
      n++;
      if (n > 200) begin
        chk("fetch_timeout", 32'(n), 32'd0);
        break;
      end
    end
    chk("hit_pred", 32'(n == 0), 32'(h));
    if (!h) begin
      chk("fill_words", 32'(acks), 32'd4);
      chk("stall_after_last_ack", 32'(last_ack), 32'd1);
      model_fill(a);
    end
    chk("mem_ren_on_hit", 32'(mem_ren), 32'd0);
    exp_hits++;
    @(posedge clk); #1;
  endtask

  task automatic wait_acks(inout int acks, input int target);
    int n;
    n = 0;
    while (acks < target && n < 200) begin
      @(negedge clk);
      if (mem_ack) acks++;
      n++;
    end
    if (acks < target) chk("ack_timeout", 32'(acks), 32'(target));
  endtask

  // Fetch that misses, then withdraws cpu_ren after two words.
  task automatic drop_fill(input logic [31:0] a);
    int acks;
    acks = 0;
    cpu_addr = a;
    cpu_ren  = 1'b1;
    wait_acks(acks, 2);
    @(posedge clk); #1;
    cpu_ren  = 1'b0;
    cpu_addr = $urandom;
    wait_acks(acks, 4);
    model_fill(a);
    @(posedge clk); #1;
    chk("mem_ren_after_drop_fill", 32'(mem_ren), 32'd0);
  endtask

  // Fetch that misses, then reset arrives after the second word.
  task automatic abort_fill(input logic [31:0] a);
    int acks;
    acks = 0;
    cpu_addr = a;
    cpu_ren  = 1'b1;
    wait_acks(acks, 2);
    @(posedge clk); #1;
    rst = 1'b1;
    @(posedge clk); #1;
    chk("mem_ren_after_rst", 32'(mem_ren), 32'd0);
    chk("mem_addr_after_rst", mem_addr, 32'd0);
    @(posedge clk); #1;
    rst     = 1'b0;
    cpu_ren = 1'b0;
    model_reset();
  endtask

  initial begin
    rst      = 1'b1;
    cpu_ren  = 1'b1;
    cpu_addr = 32'h10;
    spur_ack = 1'b0;
    spur_din = '0;
    model_reset();
    @(posedge clk); #1;
    @(posedge clk); #1;
    chk("rst_mem_ren", 32'(mem_ren), 32'd0);
    chk("rst_mem_addr", mem_addr, 32'd0);
    chk("rst_dout", cpu_dout, 32'd0);
    chk("rst_stall", 32'(cpu_stall), 32'd1);
    cnt_chk();
    rst     = 1'b0;
    cpu_ren = 1'b0;

    // Cold miss, then hits within the line.
    fetch(32'h10);
    cnt_chk();
    fetch(32'h11); fetch(32'h12); fetch(32'h13);
    cnt_chk();

    // Conflict eviction on slot 4.
    for (int i = 0; i < 4; i++) fetch(32'h30 + 32'(i));
    fetch(32'h10);
    cnt_chk();
    chk("miss_cnt_after_evict", miss_cnt, 32'd3);
    cpu_ren = 1'b0;

    // Spurious ack while idle must leave the line intact.
    @(posedge clk); #1;
    spur_din = 32'hDEAD_BEEF;
    spur_ack = 1'b1;
    @(negedge clk);
    chk("mem_ren_spur", 32'(mem_ren), 32'd0);
    @(posedge clk); #1;
    spur_ack = 1'b0;
    @(negedge clk);
    chk("mem_ren_after_spur", 32'(mem_ren), 32'd0);
    @(posedge clk); #1;
    fetch(32'h10); fetch(32'h13);
    cnt_chk();

    // Fill survives cpu_ren dropping mid-way.
    cpu_ren = 1'b0;
    drop_fill(32'h48);
    fetch(32'h48); fetch(32'h4B);
    cnt_chk();

    // Reset mid-fill, then full refill of the same line.
    abort_fill(32'h20);
    cnt_chk();
    fetch(32'h20); fetch(32'h23);
    cnt_chk();

    // Sweep of 64 words from cold.
    cpu_ren = 1'b0;
    do_reset();
    for (int a = 0; a < 64; a++) fetch(32'(a));
    chk("sweep_fills", miss_cnt, 32'd16);
    cnt_chk();

    // Randomised fetches with idle gaps.
    for (int k = 0; k < 300; k++) begin
      logic [31:0] a;
      a = ($urandom_range(0, 7) == 0) ? $urandom : 32'($urandom_range(0, 255));
      if ($urandom_range(0, 3) == 0) begin
        cpu_ren = 1'b0;
        repeat ($urandom_range(1, 2)) begin @(posedge clk); #1; end
      end
      fetch(a);
    end
    cnt_chk();
    cpu_ren = 1'b0;
    @(posedge clk); #1;
    @(posedge clk); #1;
    chk("scoreboard_drained", 32'(exp_q.size()), 32'd0);

    $display("== %0d vectors applied, %0d miscompares ==", vectors, errors);
    $finish;
  end

endmodule

// File: doc/icache_dm.md
Name: icache_dm

Overview:
- Direct-mapped, read-only instruction cache between the IF-stage fetch port and the slow instruction memory.
- The memory acknowledges one word per request after a multi-cycle delay.
- A hit returns the word in the same cycle with no stall.
- A miss stalls fetch while the block fills a whole line with sequential one-word memory reads, then resumes hitting.

Parameters:
- INDEX_WIDTH, 3, log2 of line count (8 lines).
- OFFSET_WIDTH, 2, log2 of words per line (4 words).
- TAG_WIDTH, 32-INDEX_WIDTH-OFFSET_WIDTH, tag bits. Addresses are word addresses.

Ports:
- clk  in  1  system clock; all state updates on posedge.
- rst  in  1  synchronous, active-high reset.
- cpu_addr  in  32  fetch word address; held stable by the CPU while cpu_stall=1.
- cpu_ren  in  1  fetch request.
- cpu_dout  out  32  instruction word; valid when cpu_ren & ~cpu_stall, else 0.
- cpu_stall  out  1  = cpu_ren & ~hit (combinational).
- mem_addr  out  32  word address to memory: {tag,index,fill_cnt}.
- mem_ren  out  1  memory read request.
- mem_din  in  32  memory read data; valid in the cycle mem_ack=1.
- mem_ack  in  1  one-cycle acknowledge, registered in memory.
- hit_cnt  out  32  number of cpu_ren cycles with hit, saturating.
- miss_cnt  out  32  number of line fills started, saturating.

Behaviour:
- Storage per line: valid bit, tag[TAG_WIDTH], data[2^OFFSET_WIDTH][32].
- Address split: tag=addr[31:INDEX_WIDTH+OFFSET_WIDTH], index=next INDEX_WIDTH bits, offset=low OFFSET_WIDTH bits.
- hit = valid[index] & (tag[index]==addr tag). Combinational; a hit has zero-cycle latency.
- Reset:
  - All valid bits cleared; state=S_IDLE; fill_cnt=0; hit_cnt=miss_cnt=0.
  - mem_ren=0; mem_addr=0; cpu_dout=0; cpu_stall=cpu_ren.
  - Data and tag arrays are not cleared.
- S_IDLE:
  - cpu_ren & hit: drive the word, increment hit_cnt.
  - cpu_ren & ~hit: go to S_FILL. Latch fill_tag and fill_index from cpu_addr, set fill_cnt=0, increment miss_cnt.
  - mem_ren=0.
- S_FILL:
  - mem_addr = {fill_tag, fill_index, fill_cnt}, stable until the edge where mem_ack is sampled 1.
  - mem_ren = ~(mem_ack & fill_cnt==last); combinational. It stays high between words so memory restarts immediately and no extra request is issued after the final word.
  - On a posedge with mem_ack=1: write mem_din to data[fill_index][fill_cnt] and increment fill_cnt.
  - On the final word: also set tag=fill_tag, valid=1, and return to S_IDLE. The next cycle hits.
  - The valid bit of the filling line is cleared at fill start, so a partially filled line never hits.
- Miss latency: stall from the request cycle until one cycle after the last ack; the CPU sees the hit in that cycle.
- Boundary conditions:
  - mem_ack while in S_IDLE: ignored.
  - cpu_ren drops or cpu_addr changes mid-fill: fill still completes for the latched line; no abort.
  - Reset mid-fill: returns to S_IDLE, all lines invalid. Memory shares the same rst.
  - Fill of a line that replaces a valid line: overwrite with no write-back (read-only cache).
  - fill_cnt wraps to 0 after the last word.
  - Counters saturate at 32'hFFFFFFFF.
  - Hit in the same cycle fill completes: not possible, because the hit is evaluated on the arrays before the write.

Decomposition:
- Package icache_pkg holds:
  - state encodings S_IDLE=0, S_FILL=1;
  - default INDEX_WIDTH/OFFSET_WIDTH;
  - a tag/index/offset field-extraction helper function.
- One natural sub-module, icache_ctrl: FSM, fill_cnt, mem_ren/mem_addr generation, counters.
- The top level holds the arrays and the hit comparator.

Test Plan:
1. Cold miss: memory model with 3-cycle ack delay, mem word n = 32'hA000_0000+n; rst, then cpu_addr=0x10, cpu_ren=1.
   - mem_addr sequences 0x10,0x11,0x12,0x13.
   - mem_ren stays high until the 4th ack.
   - cpu_stall drops the cycle after; cpu_dout=0xA000_0010; miss_cnt=1.
2. Line hits: after scenario 1, fetch 0x11, 0x12, 0x13 back-to-back.
   - No stall; data 0xA000_0011..0013; hit_cnt=4 (includes the post-fill hit at 0x10); mem_ren stays 0.
3. Conflict eviction: fetch 0x30 (same index 4 as 0x10 with INDEX_WIDTH=3).
   - Fill 0x30..0x33; then 0x10 misses again; miss_cnt=3.
4. Spurious and late ack: pulse mem_ack in S_IDLE.
   - No array write; no state change.
   - During a fill, drop cpu_ren mid-fill: fill completes and the line becomes valid.
5. Reset mid-fill: assert rst after the 2nd ack of a fill.
   - mem_ren=0 next cycle; re-fetch of the same address misses and refills all 4 words.
6. Index/tag sweep: fetch 0x00..0x3F sequentially.
   - Exactly 16 fills; every returned word equals its model value; 48 hits.
